alu_issue: RTL and testbench

//  Drives the RV32I integer ALU: accepts ALU-class instructions (OP, OP-IMM) with valid/ready,

---
 rtl/rv_alu_pkg.sv | 32 +++
 rtl/rv_alu_decode.sv | 98 +++++++++
 rtl/alu_issue.sv | 198 +++++++++++++++++++
 tb/tb_alu_issue.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared definitions for the RV32I ALU issue slice.
//   - Opcode, funct3 and funct7 encodings of the OP / OP-IMM instruction groups.
//   - alu_ctrl_t: the decoded control bundle handed from the decoder to the
//     issue pipeline (operand-B source, ALU mode bits, funct3, write enable,
//     illegal flag).
package rv_alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       rs2_is_imm;
    logic       sub;
    logic       sra;
    logic [2:0] func3;
    logic       we;
    logic       illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/rv_alu_decode.sv
// Purely combinational decoder for RV32I OP / OP-IMM instructions.
// Ports:
//   instr     in   32    instruction word
//   ctrl      out        decoded ALU controls (alu_ctrl_t)
//   imm       out  XLEN  operand-B immediate: sign-extended I-imm, or
//                        zero-extended shamt for shift-immediates
//   rs1_addr  out  RA_W  source register 1 field
//   rs2_addr  out  RA_W  source register 2 field
//   rd_addr   out  RA_W  destination register field
module rv_alu_decode
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [31:0]     instr,
  output alu_ctrl_t       ctrl,
  output logic [XLEN-1:0] imm,
  output logic [RA_W-1:0] rs1_addr,
  output logic [RA_W-1:0] rs2_addr,
  output logic [RA_W-1:0] rd_addr
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign rs1_addr = instr[15 +: RA_W];
  assign rs2_addr = instr[20 +: RA_W];
  assign rd_addr  = instr[7 +: RA_W];

  // Everything starts out illegal and is cleared only by a recognised
  // encoding. Shift-immediates reuse the funct7 slot of the I-immediate as
  // an encoding qualifier, so their operand is only the 5-bit shamt.
  always_comb begin
    ctrl         = '0;
    ctrl.func3   = f3;
    ctrl.illegal = 1'b1;
    imm          = {{(XLEN-12){instr[31]}}, instr[31:20]};

    case (opcode)
      OPC_OP: begin
        case (f3)
          F3_ADD: begin
            ctrl.illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            ctrl.sub     = (f7 == F7_ALT);
          end
          F3_SR: begin
            ctrl.illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            ctrl.sra     = (f7 == F7_ALT);
          end
          F3_SLT, F3_SLTU: begin
            ctrl.illegal = (f7 != F7_BASE);
            ctrl.sub     = 1'b1;
          end
          F3_SLL, F3_XOR, F3_OR, F3_AND: begin
            ctrl.illegal = (f7 != F7_BASE);
          end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        ctrl.rs2_is_imm = 1'b1;
        case (f3)
          F3_SLL: begin
            ctrl.illegal = (f7 != F7_BASE);
            imm          = {{(XLEN-5){1'b0}}, instr[24:20]};
          end
          F3_SR: begin
            ctrl.illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            ctrl.sra     = (f7 == F7_ALT);
            imm          = {{(XLEN-5){1'b0}}, instr[24:20]};
          end
          F3_SLT, F3_SLTU: begin
            ctrl.illegal = 1'b0;
            ctrl.sub     = 1'b1;
          end
          F3_ADD, F3_XOR, F3_OR, F3_AND: begin
            ctrl.illegal = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    // Illegal instructions must not steer the ALU into a special mode.
    if (ctrl.illegal) begin
      ctrl.sub = 1'b0;
      ctrl.sra = 1'b0;
    end
    ctrl.we = !ctrl.illegal && (rd_addr != '0);
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback wrapper around an external RV32I integer ALU.
// Two pipeline stages: X holds registered ALU controls and operands, W holds
// the captured result presented as a writeback. One instruction per cycle
// with optional operand forwarding from X and W.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr   instruction input handshake
//   rf_raddr1/2, rf_rdata1/2     combinational register-file read
//   alu_rs1/rs2/sub/sra/func3    registered ALU operands and controls
//   alu_result                   combinational ALU result for X contents
//   wb_valid/wb_ready            writeback handshake
//   wb_rd/wb_we/wb_data/wb_illegal  writeback payload
module alu_issue
  import rv_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [RA_W-1:0] rf_raddr1,
  output logic [RA_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic            alu_sub,
  output logic            alu_sra,
  output logic [2:0]      alu_func3,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RA_W-1:0] wb_rd,
  output logic            wb_we,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal
);

  alu_ctrl_t       dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic [RA_W-1:0] dec_rs1;
  logic [RA_W-1:0] dec_rs2;
  logic [RA_W-1:0] dec_rd;

  logic            x_valid_q, x_valid_d;
  logic [RA_W-1:0] x_rd_q, x_rd_d;
  logic            x_we_q, x_we_d;
  logic            x_illegal_q, x_illegal_d;
  logic [XLEN-1:0] alu_rs1_q, alu_rs1_d;
  logic [XLEN-1:0] alu_rs2_q, alu_rs2_d;
  logic            alu_sub_q, alu_sub_d;
  logic            alu_sra_q, alu_sra_d;
  logic [2:0]      alu_func3_q, alu_func3_d;

  logic            wb_valid_q, wb_valid_d;
  logic [RA_W-1:0] wb_rd_q, wb_rd_d;
  logic            wb_we_q, wb_we_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_illegal_q, wb_illegal_d;

  logic            x_adv;
  logic            accept;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  rv_alu_decode #(
    .XLEN(XLEN),
    .RA_W(RA_W)
  ) u_decode (
    .instr   (in_instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .rs1_addr(dec_rs1),
    .rs2_addr(dec_rs2),
    .rd_addr (dec_rd)
  );

  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  // X advances whenever W is free or being drained; a new instruction can
  // enter X whenever X is empty or emptying this cycle.
  assign x_adv    = x_valid_q & (~wb_valid_q | wb_ready);
  assign in_ready = ~x_valid_q | x_adv;
  assign accept   = in_valid & in_ready;

  // Operand forwarding. Assignments are ordered so that the later (younger)
  // X hit overrides the W hit. An accept with X occupied implies X is
  // advancing, so alu_result is exactly the value X is about to retire.
  always_comb begin
    op_a = rf_rdata1;
    op_b = rf_rdata2;
    if (BYPASS != 0) begin
      if (wb_valid_q && wb_we_q && (wb_rd_q == dec_rs1)) op_a = wb_data_q;
      if (x_valid_q && x_we_q && (x_rd_q == dec_rs1))    op_a = alu_result;
      if (wb_valid_q && wb_we_q && (wb_rd_q == dec_rs2)) op_b = wb_data_q;
      if (x_valid_q && x_we_q && (x_rd_q == dec_rs2))    op_b = alu_result;
    end
    if (dec_rs1 == '0) op_a = '0;
    if (dec_rs2 == '0) op_b = '0;
  end

  // X stage: contents hold while stalled; when the stage is free it takes
  // whatever is being accepted (or becomes empty).
  always_comb begin
    x_valid_d   = x_valid_q;
    x_rd_d      = x_rd_q;
    x_we_d      = x_we_q;
    x_illegal_d = x_illegal_q;
    alu_rs1_d   = alu_rs1_q;
    alu_rs2_d   = alu_rs2_q;
    alu_sub_d   = alu_sub_q;
    alu_sra_d   = alu_sra_q;
    alu_func3_d = alu_func3_q;
    if (in_ready) begin
      x_valid_d = accept;
      if (accept) begin
        x_rd_d      = dec_rd;
        x_we_d      = dec_ctrl.we;
        x_illegal_d = dec_ctrl.illegal;
        alu_rs1_d   = op_a;
        alu_rs2_d   = dec_ctrl.rs2_is_imm ? dec_imm : op_b;
        alu_sub_d   = dec_ctrl.sub;
        alu_sra_d   = dec_ctrl.sra;
        alu_func3_d = dec_ctrl.func3;
      end
    end
  end

  // W stage: captures the ALU result on X advance; illegal instructions
  // carry a zero result. The payload holds after consumption until reloaded.
  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_rd_d      = wb_rd_q;
    wb_we_d      = wb_we_q;
    wb_data_d    = wb_data_q;
    wb_illegal_d = wb_illegal_q;
    if (x_adv) begin
      wb_valid_d   = 1'b1;
      wb_rd_d      = x_rd_q;
      wb_we_d      = x_we_q;
      wb_illegal_d = x_illegal_q;
      wb_data_d    = x_illegal_q ? '0 : alu_result;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_valid_q    <= 1'b0;
      x_rd_q       <= '0;
      x_we_q       <= 1'b0;
      x_illegal_q  <= 1'b0;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
      alu_sub_q    <= 1'b0;
      alu_sra_q    <= 1'b0;
      alu_func3_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_we_q      <= 1'b0;
      wb_data_q    <= '0;
      wb_illegal_q <= 1'b0;
    end else begin
      x_valid_q    <= x_valid_d;
      x_rd_q       <= x_rd_d;
      x_we_q       <= x_we_d;
      x_illegal_q  <= x_illegal_d;
      alu_rs1_q    <= alu_rs1_d;
      alu_rs2_q    <= alu_rs2_d;
      alu_sub_q    <= alu_sub_d;
      alu_sra_q    <= alu_sra_d;
      alu_func3_q  <= alu_func3_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_we_q      <= wb_we_d;
      wb_data_q    <= wb_data_d;
      wb_illegal_q <= wb_illegal_d;
    end
  end

  assign alu_rs1    = alu_rs1_q;
  assign alu_rs2    = alu_rs2_q;
  assign alu_sub    = alu_sub_q;
  assign alu_sra    = alu_sra_q;
  assign alu_func3  = alu_func3_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_we      = wb_we_q;
  assign wb_data    = wb_data_q;
  assign wb_illegal = wb_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue. Provides a register file that is written
// from consumed writebacks and an ALU driven by the DUT's X-stage outputs.
// Expected writebacks come from an architectural model that executes each
// accepted instruction in program order against its own register array.
module tb_alu_issue;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        illegal;
  } wb_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [RA_W-1:0] rf_raddr1, rf_raddr2;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [XLEN-1:0] alu_rs1, alu_rs2;
  logic            alu_sub, alu_sra;
  logic [2:0]      alu_func3;
  logic [XLEN-1:0] alu_result;
  logic            wb_valid, wb_ready;
  logic [RA_W-1:0] wb_rd;
  logic            wb_we;
  logic [XLEN-1:0] wb_data;
  logic            wb_illegal;

  logic [31:0] rf   [32];
  logic [31:0] arch [32];
  wb_t         exp_q[$];
  logic        pend_we;
  logic [4:0]  pend_rd;
  logic [31:0] pend_data;
  logic        last_accept;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(XLEN), .RA_W(RA_W), .BYPASS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .alu_rs1   (alu_rs1),
    .alu_rs2   (alu_rs2),
    .alu_sub   (alu_sub),
    .alu_sra   (alu_sra),
    .alu_func3 (alu_func3),
    .alu_result(alu_result),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_we     (wb_we),
    .wb_data   (wb_data),
    .wb_illegal(wb_illegal)
  );

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // External ALU attached to the X stage.
  always_comb begin
    alu_result = '0;
    case (alu_func3)
      3'd0: alu_result = alu_sub ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
      3'd1: alu_result = alu_rs1 << alu_rs2[4:0];
      3'd2: alu_result = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
      3'd3: alu_result = {31'b0, alu_rs1 < alu_rs2};
      3'd4: alu_result = alu_rs1 ^ alu_rs2;
      3'd5: alu_result = alu_sra ? 32'($signed(alu_rs1) >>> alu_rs2[4:0])
                                 : alu_rs1 >> alu_rs2[4:0];
      3'd6: alu_result = alu_rs1 | alu_rs2;
      3'd7: alu_result = alu_rs1 & alu_rs2;
      default: ;
    endcase
  end

  // Architectural execution of one instruction against arch[].
  function automatic wb_t refExec(input logic [31:0] instr);
    wb_t         r;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, imm, res;
    logic [4:0]  sh;
    logic        legal;
    opc   = instr[6:0];
    f3    = instr[14:12];
    f7    = instr[31:25];
    a     = (instr[19:15] == 5'd0) ? 32'd0 : arch[instr[19:15]];
    b     = (instr[24:20] == 5'd0) ? 32'd0 : arch[instr[24:20]];
    imm   = {{20{instr[31]}}, instr[31:20]};
    sh    = instr[24:20];
    legal = 1'b0;
    res   = 32'd0;
    if (opc == 7'h33) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      case (f3)
        3'd0: res = (f7 == 7'h20) ? a - b : a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end else if (opc == 7'h13) begin
      legal = 1'b1;
      case (f3)
        3'd0: res = a + imm;
        3'd1: begin legal = (f7 == 7'h00); res = a << sh; end
        3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: res = (a < imm) ? 32'd1 : 32'd0;
        3'd4: res = a ^ imm;
        3'd5: begin
          legal = (f7 == 7'h00) || (f7 == 7'h20);
          res   = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
        end
        3'd6: res = a | imm;
        default: res = a & imm;
      endcase
    end
    r.rd      = instr[11:7];
    r.illegal = !legal;
    r.data    = legal ? res : 32'd0;
    r.we      = legal && (instr[11:7] != 5'd0);
    return r;
  endfunction

  function automatic logic [31:0] mkAddi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic [6:0] opc;
    int         kind, p;
    kind = $urandom_range(0, 9);
    rd   = 5'($urandom_range(0, 7));
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    f3   = 3'($urandom_range(0, 7));
    p    = $urandom_range(0, 7);
    f7   = (p < 5) ? 7'h00 : (p < 7) ? 7'h20 : 7'($urandom);
    if (kind < 4) return {f7, rs2, rs1, f3, rd, 7'h33};
    if (kind < 8) begin
      if (f3 == 3'd1 || f3 == 3'd5) return {f7, rs2, rs1, f3, rd, 7'h13};
      return {12'($urandom), rs1, f3, rd, 7'h13};
    end
    opc = 7'($urandom);
    if (opc == 7'h33 || opc == 7'h13) opc = 7'h7F;
    return {25'($urandom), opc};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic ready);
    in_valid = valid;
    in_instr = instr;
    wb_ready = ready;
  endtask

  task automatic setReg(input int idx, input logic [31:0] val);
    rf[idx]   = val;
    arch[idx] = val;
  endtask

  // One clock: score handshakes at the falling edge, then after the rising
  // edge apply any register-file write from a consumed writeback.
  task automatic cycle();
    wb_t e;
    @(negedge clk);
    last_accept = 1'b0;
    if (rst_n) begin
      if (wb_valid && wb_ready) begin
        checkOutput("wb_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
          checkOutput("wb_we", 32'(wb_we), 32'(e.we));
          checkOutput("wb_data", wb_data, e.data);
          checkOutput("wb_illegal", 32'(wb_illegal), 32'(e.illegal));
        end
        if (wb_we && wb_rd != 5'd0) begin
          pend_we   = 1'b1;
          pend_rd   = wb_rd;
          pend_data = wb_data;
        end
      end
      if (in_valid && in_ready) begin
        last_accept = 1'b1;
        e = refExec(in_instr);
        exp_q.push_back(e);
        if (e.we) arch[e.rd] = e.data;
      end
    end
    @(posedge clk);
    #1;
    if (pend_we) rf[pend_rd] = pend_data;
    pend_we = 1'b0;
  endtask

  // Present one instruction into an empty pipeline; returns with it in X.
  task automatic issueSolo(input logic [31:0] instr);
    applyStimulus(1'b1, instr, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] stream[4];
    logic [31:0] cur;
    logic        cur_valid, acc;
    int          idx;

    for (int i = 0; i < 32; i++) begin
      rf[i]   = 32'd0;
      arch[i] = 32'd0;
    end
    pend_we = 1'b0; pend_rd = '0; pend_data = '0; last_accept = 1'b0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_alu_rs1", alu_rs1, 32'd0);
    checkOutput("rst_alu_rs2", alu_rs2, 32'd0);
    checkOutput("rst_alu_ctl", {29'b0, alu_sub, alu_sra, 1'b0}, 32'd0);
    checkOutput("rst_alu_func3", 32'(alu_func3), 32'd0);
    checkOutput("rst_wb_payload", {26'b0, wb_rd, wb_we}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_wb_illegal", 32'(wb_illegal), 32'd0);
    rst_n = 1'b1;
    cycle();

    // addi x1,x0,5: two cycles to writeback
    issueSolo(32'h00500093);
    checkOutput("addi_x_rs2", alu_rs2, 32'd5);
    checkOutput("addi_early_wb", 32'(wb_valid), 32'd0);
    cycle();
    checkOutput("addi_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("addi_wb_rd", 32'(wb_rd), 32'd1);
    checkOutput("addi_wb_we", 32'(wb_we), 32'd1);
    checkOutput("addi_wb_data", wb_data, 32'd5);
    cycle();

    // sub x3,x1,x2 with x1=7, x2=9
    setReg(1, 32'd7); setReg(2, 32'd9);
    issueSolo(32'h402081B3);
    checkOutput("sub_alu_sub", 32'(alu_sub), 32'd1);
    checkOutput("sub_func3", 32'(alu_func3), 32'd0);
    checkOutput("sub_rs1", alu_rs1, 32'd7);
    checkOutput("sub_rs2", alu_rs2, 32'd9);
    cycle();
    checkOutput("sub_wb_data", wb_data, 32'hFFFFFFFE);
    cycle();

    // Back-to-back dependency through X forwarding
    setReg(1, 32'd0); setReg(2, 32'd0);
    applyStimulus(1'b1, 32'h00500093, 1'b1);
    cycle();
    applyStimulus(1'b1, 32'h00308113, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("fwd_x_rs1", alu_rs1, 32'd5);
    checkOutput("fwd_x_rs2", alu_rs2, 32'd3);
    cycle();
    checkOutput("fwd_wb_data", wb_data, 32'd8);
    checkOutput("fwd_wb_rd", 32'(wb_rd), 32'd2);
    cycle();

    // srai x4,x1,4 on a negative value
    setReg(1, 32'h80000000);
    issueSolo(32'h4040D213);
    checkOutput("srai_alu_sra", 32'(alu_sra), 32'd1);
    checkOutput("srai_alu_rs2", alu_rs2, 32'd4);
    cycle();
    checkOutput("srai_wb_data", wb_data, 32'hF8000000);
    cycle();

    // slli with funct7=0100000, unknown opcode, write to x0
    issueSolo(32'h40109293);
    cycle();
    checkOutput("slli_alt_illegal", 32'(wb_illegal), 32'd1);
    checkOutput("slli_alt_we", 32'(wb_we), 32'd0);
    checkOutput("slli_alt_data", wb_data, 32'd0);
    cycle();
    issueSolo(32'h0000007F);
    cycle();
    checkOutput("badop_illegal", 32'(wb_illegal), 32'd1);
    checkOutput("badop_we", 32'(wb_we), 32'd0);
    cycle();
    issueSolo(32'h00100013);
    cycle();
    checkOutput("x0_we", 32'(wb_we), 32'd0);
    checkOutput("x0_illegal", 32'(wb_illegal), 32'd0);
    cycle();

    // Writeback stall with a 4-instruction dependent stream
    stream[0] = mkAddi(5, 0, 1);
    stream[1] = mkAddi(6, 5, 2);
    stream[2] = mkAddi(7, 6, 3);
    stream[3] = mkAddi(5, 7, 4);
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      applyStimulus(idx < 4, (idx < 4) ? stream[idx] : 32'h0, !(c >= 2 && c <= 4));
      #1;
      if (c == 2 || c == 4) begin
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("stall_wb_hold", wb_data, 32'd1);
      end
      acc = in_valid && in_ready;
      cycle();
      if (acc) idx++;
    end
    checkOutput("stall_accepted", 32'(idx), 32'd4);
    checkOutput("stall_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("stall_x5", rf[5], 32'd10);
    checkOutput("stall_x6", rf[6], 32'd3);
    checkOutput("stall_x7", rf[7], 32'd6);

    // Reset in the middle of a stream discards in-flight instructions
    applyStimulus(1'b1, mkAddi(8, 0, 11), 1'b1);
    cycle();
    applyStimulus(1'b1, mkAddi(9, 8, 1), 1'b1);
    cycle();
    applyStimulus(1'b1, mkAddi(10, 0, 7), 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_alu_rs1", alu_rs1, 32'd0);
    exp_q.delete();
    pend_we = 1'b0;
    for (int i = 0; i < 32; i++) arch[i] = rf[i];
    applyStimulus(1'b0, 32'h0, 1'b1);
    cycle();
    rst_n = 1'b1;
    cycle();
    checkOutput("midrst_x8", rf[8], 32'd0);
    checkOutput("midrst_x9", rf[9], 32'd0);

    // Randomised traffic with random back-pressure
    for (int i = 1; i < 8; i++) setReg(i, $urandom);
    cur_valid = 1'b0;
    cur = 32'h0;
    for (int c = 0; c < 600; c++) begin
      if (!cur_valid || last_accept) begin
        cur_valid = ($urandom_range(0, 3) != 0);
        cur       = randInstr();
      end
      applyStimulus(cur_valid, cur, ($urandom_range(0, 3) != 0));
      cycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) cycle();
    checkOutput("rand_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < 8; i++) checkOutput($sformatf("rand_x%0d", i), rf[i], arch[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
